// File: rtl/res_display_pkg.sv
// Shared types and constants for the reaction-time result display:
// converter state encoding, result width and 7-segment patterns.
package res_display_pkg;

  localparam int RES_W = 9;
  localparam int BCD_W = 12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Segment patterns are {g,f,e,d,c,b,a}, active-low.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Entry [n] holds the pattern for decimal digit n.
  localparam logic [9:0][6:0] SEG_DIGITS = {
    7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010,
    7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    if (d > 4'd9) return SEG_BLANK;
    return SEG_DIGITS[d];
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one shift-add-3 step per clock.
// A start seen in IDLE captures bin; nine CONV cycles follow, then a single
// DONE cycle during which bcd is valid and done is high.
module bin2bcd_seq
  import res_display_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [RES_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);

  localparam int         SR_W    = BCD_W + RES_W;
  localparam logic [3:0] LAST_IT = 4'(RES_W - 1);

  state_t          state;
  state_t          state_nxt;
  logic [3:0]      it_cnt;
  logic [SR_W-1:0] sr;

  // Add 3 to every BCD nibble that is 5 or more, then shift the whole
  // register left by one so the next binary bit enters the ones nibble.
  function automatic logic [SR_W-1:0] dabble_step(input logic [SR_W-1:0] v);
    logic [SR_W-1:0] a;
    a = v;
    for (int i = 0; i < BCD_W / 4; i++) begin
      if (a[RES_W + 4*i +: 4] >= 4'd5)
        a[RES_W + 4*i +: 4] = a[RES_W + 4*i +: 4] + 4'd3;
    end
    return {a[SR_W-2:0], 1'b0};
  endfunction

  // State register; reset aborts any conversion in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: IDLE -> CONV on start, CONV for RES_W steps, DONE for one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_CONV;
      ST_CONV: if (it_cnt == LAST_IT) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Iteration counter, cleared whenever the converter is not converting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  it_cnt <= 4'd0;
    else if (state == ST_CONV) it_cnt <= it_cnt + 4'd1;
    else                      it_cnt <= 4'd0;
  end

  // Data shift register: load on accepted start, one dabble step per CONV cycle.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && start) sr <= {{BCD_W{1'b0}}, bin};
    else if (state == ST_CONV)     sr <= dabble_step(sr);
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);
  assign bcd  = sr[SR_W-1:RES_W];

endmodule

// File: rtl/res_display.sv
// Four-digit multiplexed 7-segment display of a reaction-time result.
// A change of res starts a 10-cycle BCD conversion; the digit registers are
// only updated when the conversion completes, so partial digits never show.
// The leftmost digit shows a dash while the hint lamp is on.
// Optional build macro LZ_BLANK_EN blanks leading zero hundreds/tens digits.
module res_display
  import res_display_pkg::*;
#(
  parameter int SCAN_DIV = 25000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [8:0] res,
  input  logic       hint,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       busy
);

  localparam logic [19:0] SCAN_LAST = 20'(SCAN_DIV - 1);

  logic [RES_W-1:0] last;
  logic [RES_W-1:0] cap;
  logic             start;
  logic             conv_done;
  logic [BCD_W-1:0] bcd;
  logic [3:0]       hund;
  logic [3:0]       tens;
  logic [3:0]       ones;
  logic             hund_blank;
  logic             tens_blank;
  logic [19:0]      scan_cnt;
  logic [1:0]       idx;
  logic [1:0]       idx_nxt;
  logic [3:0]       an_nxt;
  logic [6:0]       seg_nxt;

  // The converter only honours start while idle, so res changes during a
  // conversion are ignored until it returns to IDLE.
  assign start = (res != last);

  bin2bcd_seq u_conv (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (res),
    .busy  (busy),
    .done  (conv_done),
    .bcd   (bcd)
  );

  // Remember the value being converted so last matches the shown digits.
  always_ff @(posedge clk) begin
    if (start && !busy) cap <= res;
  end

  // Displayed digits and last change together, only when a conversion completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hund <= 4'd0;
      tens <= 4'd0;
      ones <= 4'd0;
      last <= '0;
    end else if (conv_done) begin
      {hund, tens, ones} <= bcd;
      last               <= cap;
    end
  end

`ifdef LZ_BLANK_EN
  assign hund_blank = (hund == 4'd0);
  assign tens_blank = (hund == 4'd0) && (tens == 4'd0);
`else
  assign hund_blank = 1'b0;
  assign tens_blank = 1'b0;
`endif

  // Anode and segment pattern for the digit that the next scan tick selects.
  always_comb begin
    idx_nxt = idx + 2'd1;
    an_nxt  = ~(4'b0001 << idx_nxt);
    seg_nxt = SEG_BLANK;
    case (idx_nxt)
      2'd0:    seg_nxt = seg_of(ones);
      2'd1:    seg_nxt = tens_blank ? SEG_BLANK : seg_of(tens);
      2'd2:    seg_nxt = hund_blank ? SEG_BLANK : seg_of(hund);
      default: seg_nxt = hint ? SEG_DASH : SEG_BLANK;
    endcase
  end

  // Scan divider; each wrap advances the digit index and registers an/seg.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt <= 20'd0;
      idx      <= 2'd3;
      an       <= 4'b1111;
      seg      <= SEG_BLANK;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= 20'd0;
      idx      <= idx_nxt;
      an       <= an_nxt;
      seg      <= seg_nxt;
    end else begin
      scan_cnt <= scan_cnt + 20'd1;
    end
  end

endmodule

// File: tb/tb_res_display.sv
// Self-checking bench for res_display with SCAN_DIV=4: a table of known
// results with hand-derived segment patterns, hand-written timing sequences
// (busy window, mid-conversion change, reset mid-conversion) and random
// results checked against a decimal-arithmetic display model.
module tb_res_display;

  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] DASH  = 7'b0111111;
`ifdef LZ_BLANK_EN
  localparam logic [6:0] ZL = 7'b1111111;
`else
  localparam logic [6:0] ZL = 7'b1000000;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [8:0] res;
  logic       hint;
  logic [6:0] seg;
  logic [3:0] an;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  int model_last = 0;

  typedef struct {
    int               res;
    bit               hint;
    logic [3:0][6:0]  exp;
  } vec_t;

  vec_t tbl [6];

  res_display #(.SCAN_DIV(4)) dut (
    .clk,
    .rst,
    .res,
    .hint,
    .seg,
    .an,
    .busy
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input int v, input bit h);
    res  = 9'(v);
    hint = h;
  endtask

  function automatic logic [6:0] dig_seg(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Reference: decimal digits of v, leading-zero rule, hint dash on index 3.
  function automatic logic [3:0][6:0] exp_round(input int v, input bit h);
    int hu, te, on;
    logic [3:0][6:0] r;
    hu = v / 100;
    te = (v / 10) % 10;
    on = v % 10;
    r[0] = dig_seg(on);
    r[1] = dig_seg(te);
    r[2] = dig_seg(hu);
    r[3] = h ? DASH : BLANK;
`ifdef LZ_BLANK_EN
    if (hu == 0) begin
      r[2] = BLANK;
      if (te == 0) r[1] = BLANK;
    end
`endif
    return r;
  endfunction

  // Called right after res was driven to a value differing from last:
  // busy must be high for exactly 10 samples starting after the next edge.
  task automatic expect_conv(input string name);
    int n;
    n = 0;
    tick();
    while (busy === 1'b1 && n < 30) begin
      n++;
      tick();
    end
    check({name, "_busy_cycles"}, n, 10);
  endtask

  // Skip one scan period so stale patterns are gone, then collect one full round.
  task automatic read_round(output logic [3:0][6:0] got, output logic [3:0] seen,
                            output logic onehot_ok);
    got = '1;
    seen = '0;
    onehot_ok = 1'b1;
    repeat (4) tick();
    for (int c = 0; c < 16; c++) begin
      tick();
      case (an)
        4'b1110: begin got[0] = seg; seen[0] = 1'b1; end
        4'b1101: begin got[1] = seg; seen[1] = 1'b1; end
        4'b1011: begin got[2] = seg; seen[2] = 1'b1; end
        4'b0111: begin got[3] = seg; seen[3] = 1'b1; end
        default: onehot_ok = 1'b0;
      endcase
    end
  endtask

  task automatic check_round(input string name, input logic [3:0][6:0] exp);
    logic [3:0][6:0] got;
    logic [3:0]      seen;
    logic            ok;
    read_round(got, seen, ok);
    check({name, "_an_onehot"}, ok, 1);
    for (int i = 0; i < 4; i++)
      check($sformatf("%s_idx%0d", name, i), {seen[i], got[i]}, {1'b1, exp[i]});
  endtask

  task automatic set_vec(input int i, input int v, input bit h, input logic [6:0] s3,
                         input logic [6:0] s2, input logic [6:0] s1, input logic [6:0] s0);
    tbl[i].res  = v;
    tbl[i].hint = h;
    tbl[i].exp  = {s3, s2, s1, s0};
  endtask

  initial begin
    logic [3:0][6:0] e100;
    logic [3:0]      prev_an;
    bit              fresh;
    int              n_mon;
    int              v;
    bit              h;

    set_vec(0, 511, 1, DASH,  7'b0010010, 7'b1111001, 7'b1111001);
    set_vec(1,   5, 0, BLANK, ZL,         ZL,         7'b0010010);
    set_vec(2,  90, 1, DASH,  ZL,         7'b0010000, 7'b1000000);
    set_vec(3, 206, 0, BLANK, 7'b0100100, 7'b1000000, 7'b0000010);
    set_vec(4,   8, 1, DASH,  ZL,         ZL,         7'b0000000);
    set_vec(5, 463, 0, BLANK, 7'b0011001, 7'b0000010, 7'b0110000);

    // Reset state, then first scan tick selects index 0 after four edges.
    rst = 1'b1;
    drive(0, 0);
    repeat (3) @(negedge clk);
    check("rst_an", an, 4'b1111);
    check("rst_seg", seg, 7'b1111111);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check($sformatf("pre_tick_an_%0d", i), an, 4'b1111);
    end
    tick();
    check("first_tick_an", an, 4'b1110);
    check("first_tick_seg", seg, 7'b1000000);
    check("first_busy", busy, 0);

    // 0 -> 347: 10-cycle busy window, then 3/4/7 in the next round.
    drive(347, 0);
    expect_conv("r347");
    model_last = 347;
    check_round("r347", {BLANK, 7'b0110000, 7'b0011001, 7'b1111000});

    // Table of results with hand-derived patterns (includes 511 then 5).
    for (int i = 0; i < 6; i++) begin
      drive(tbl[i].res, tbl[i].hint);
      expect_conv($sformatf("tbl%0d", i));
      model_last = tbl[i].res;
      check_round($sformatf("tbl%0d", i), tbl[i].exp);
    end

    // 100 -> 200 mid-conversion: 100 lands at k+10, retrigger at k+11, 200 at k+21.
    drive(100, 0);
    tick();
    check("chg_busy_k", busy, 1);
    tick();
    tick();
    res = 9'd200;
    repeat (7) tick();
    check("chg_busy_k9", busy, 1);
    tick();
    check("chg_busy_k10", busy, 0);
    e100 = exp_round(100, 0);
    prev_an = an;
    fresh = 1'b0;
    n_mon = 0;
    for (int c = 11; c <= 21; c++) begin
      tick();
      if (c <= 20) check($sformatf("chg_busy_k%0d", c), busy, 1);
      else         check("chg_busy_k21", busy, 0);
      if (an != prev_an) fresh = 1'b1;
      if (fresh) begin
        n_mon++;
        case (an)
          4'b1110: check("chg_show100_idx0", seg, e100[0]);
          4'b1101: check("chg_show100_idx1", seg, e100[1]);
          4'b1011: check("chg_show100_idx2", seg, e100[2]);
          4'b0111: check("chg_show100_idx3", seg, e100[3]);
          default: check("chg_an_onehot", an, 4'b1110);
        endcase
      end
    end
    check("chg_monitor_saw_tick", n_mon > 0, 1);
    model_last = 200;
    check_round("chg200", exp_round(200, 0));

    // Hint alone toggles index 3 without any conversion.
    hint = 1'b1;
    check_round("hint_on", exp_round(200, 1));
    check("hint_on_busy", busy, 0);
    hint = 1'b0;
    check_round("hint_off", exp_round(200, 0));

    // Reset asserted during cycle k+5 of a conversion, then restart from IDLE.
    drive(321, 1);
    repeat (5) tick();
    check("rstmid_busy_before", busy, 1);
    #1 rst = 1'b1;
    #1;
    check("rstmid_an", an, 4'b1111);
    check("rstmid_seg", seg, 7'b1111111);
    check("rstmid_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    model_last = 0;
    expect_conv("rstmid_restart");
    model_last = 321;
    check_round("rstmid", exp_round(321, 1));

    // Random results and hint values against the arithmetic model.
    for (int t = 0; t < 12; t++) begin
      v = int'($urandom_range(0, 511));
      if (t == 5) v = model_last;
      h = bit'($urandom_range(0, 1));
      drive(v, h);
      if (v != model_last) begin
        expect_conv($sformatf("rnd%0d", t));
        model_last = v;
      end else begin
        tick();
        tick();
        check($sformatf("rnd%0d_same_busy", t), busy, 0);
      end
      check_round($sformatf("rnd%0d", t), exp_round(model_last, h));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
